arm_ex_stage: RTL and testbench
===============================

ARM_EX_STAGE -- requirements
Module: arm_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for every register in the block.
REQ-002 rst_b  in  1  reset, asynchronous and active-low.
REQ-003 IDEX_rn_data, IDEX_rm_data, IDEX_rs_or_rd_data  in  32 each  Rn, Rm, and Rs/store-data operands.
REQ-004 IDEX_rd_we, IDEX_cpsr_we, IDEX_is_imm, IDEX_alu_or_mac, IDEX_up_down, IDEX_mac_sel, IDEX_rd_sel, IDEX_rd_data_sel, IDEX_is_alu_for_mem_addr, IDEX_ld_byte_or_word, IDEX_halted  in  1 each  decoded controls.
- alu_or_mac: 1 = ALU, 0 = MAC.
- mac_sel: 1 = MLA.
- up_down: 1 = add offset.
- rd_sel: 1 = inst[15:12], 0 = inst[19:16].
REQ-005 IDEX_alu_sel (ARM data-processing opcode), IDEX_cpsr_mask (NZCV write mask, bit3 = N), IDEX_mem_write_en  in  4 each.
REQ-006 IDEX_cpsr  in  32  CPSR seen by the instruction; IDEX_inst_11_0  in  12; IDEX_inst_19_16, IDEX_inst_15_12  in  4 each.
REQ-007 EXID_rd_we, EXID_cpsr_we  out  1; EXID_rd_num  out  4; EXID_cpsr  out  32. Combinational forwarding view of the instruction now in EX.
REQ-008 ex_busy  out  1  the multiplier occupies EX; ID and IF hold.
REQ-009 EXMEM_alu_result, EXMEM_store_data, EXMEM_cpsr  out  32 each; EXMEM_rd_num, EXMEM_mem_write_en  out  4 each; EXMEM_rd_we, EXMEM_cpsr_we, EXMEM_rd_data_sel, EXMEM_ld_byte_or_word, EXMEM_halted  out  1 each. All registered.

Function
REQ-010 Operand2, when is_imm=1: inst[7:0] rotated right by 2*inst[11:8]. Shifter carry = bit31 of the result if the rotation is nonzero, otherwise CPSR C.
REQ-011 Operand2, when is_imm=0: Rm shifted by amount inst[11:7] with type inst[6:5] (LSL/LSR/ASR/ROR).
- Amount 0: LSR and ASR mean 32; ROR means RRX.
- Shifter carry follows ARM rules.
REQ-012 The ALU implements all 16 opcodes: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
- ADC/SBC/RSC use IDEX_cpsr[29] as carry in.
- TST/TEQ/CMP/CMN force rd_we=0.
REQ-013 Flags:
- N = result[31]; Z = (result == 0).
- Arithmetic ops: C = adder carry (carry = NOT borrow for subtracts); V = signed overflow.
- Logical ops: C = shifter carry; V unchanged.
- Only bits selected by cpsr_mask change, and only when cpsr_we=1.
REQ-014 When is_alu_for_mem_addr=1: result = Rn + Operand2 if up_down=1, else Rn - Operand2. No flag update.
REQ-015 EXMEM_store_data = IDEX_rs_or_rd_data. Destination number is selected by rd_sel.
REQ-016 FSM states: IDLE, MUL. Accepting an IDEX instruction with alu_or_mac=0 and rd_we=1 while in IDLE:
- Latches Rm and Rs.
- Latches the accumulator: Rn if mac_sel=1, else 0.
- Latches rd_num and halted.
- Goes to MUL with a 2-bit count of 0.
REQ-017 Each MUL cycle adds Rm * Rs[8*cnt+7 : 8*cnt], shifted left by 8*cnt, into the accumulator (mod 2^32) and increments cnt.
- At cnt=3 the final sum is written to EXMEM_alu_result with EXMEM_rd_we=1 and rd_data_sel=1, and the FSM returns to IDLE.
REQ-018 MUL latency: accepted at edge N, result visible after edge N+4.
- ex_busy = 1 exactly while in MUL (4 cycles).
- EXMEM carries a bubble after edges N..N+3.
- MUL never writes CPSR.
REQ-019 While ex_busy=1, IDEX inputs are ignored.
REQ-020 Bubble definition: rd_we=0, cpsr_we=0, mem_write_en=0, halted=0.
REQ-021 EXID_* outputs:
- For an ALU instruction: the rd_we, rd_num, and cpsr_we it will write at the next edge, and EXID_cpsr = the updated CPSR.
- In MUL: EXID_rd_we=1 with the latched rd_num, and EXID_cpsr_we=0.
REQ-022 Non-MUL instructions in IDLE have 1-cycle latency; a bubble input produces a bubble output.
REQ-023 EXMEM_cpsr is the updated CPSR when cpsr_we=1, otherwise IDEX_cpsr.
REQ-024 IDEX_halted propagates to EXMEM_halted with the instruction's latency.

Reset
REQ-025 While rst_b=0, asynchronously:
- FSM = IDLE, cnt = 0, ex_busy = 0.
- EXMEM_rd_we = EXMEM_cpsr_we = EXMEM_halted = 0; EXMEM_mem_write_en = 0.
- EXMEM data, cpsr, and rd_num = 0.
REQ-026 Reset during MUL abandons the product; no write is issued after release.

Verification
REQ-027 ADD, Rn=0x7FFFFFFF, imm 1, cpsr_we=1, mask=0xF -> result 0x80000000; N=1 Z=0 C=0 V=1 after 1 edge.
REQ-028 MOV with Rm=0x80000001, LSR #0 -> result 0, C=1, Z=1.
REQ-029 MLA with Rm=0x12345678, Rs=0x9ABCDEF0, Rn=5 -> ex_busy high 4 cycles, then EXMEM_alu_result=0x242D2085 with rd_we=1, and no writes during the 4 bubble cycles.
REQ-030 LDR address, Rn=0x100, imm 0x0C, up_down=0 -> 0xF4; store_data passes through; flags unchanged.
REQ-031 CMP, Rn=3, imm 3, mask=0xF -> rd_we=0, Z=1, C=1; EXID_cpsr shows the new flags in the same cycle.
REQ-032 rst_b low in the 2nd MUL cycle -> all outputs zero at once; after release, no spurious write and ex_busy=0.

Source files
------------

// File: rtl/arm_ex_stage.sv
// Execute stage of a 5-stage ARM pipeline. Holds the barrel shifter, the 16-opcode ALU with NZCV
// generation, the load/store address adder, and a 4-cycle byte-serial MUL/MLA unit.
module arm_ex_stage (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] IDEX_rn_data,
    input  logic [31:0] IDEX_rm_data,
    input  logic [31:0] IDEX_rs_or_rd_data,
    input  logic        IDEX_rd_we,
    input  logic        IDEX_cpsr_we,
    input  logic        IDEX_is_imm,
    input  logic        IDEX_alu_or_mac,
    input  logic        IDEX_up_down,
    input  logic        IDEX_mac_sel,
    input  logic        IDEX_rd_sel,
    input  logic        IDEX_rd_data_sel,
    input  logic        IDEX_is_alu_for_mem_addr,
    input  logic        IDEX_ld_byte_or_word,
    input  logic        IDEX_halted,
    input  logic [3:0]  IDEX_alu_sel,
    input  logic [3:0]  IDEX_cpsr_mask,
    input  logic [3:0]  IDEX_mem_write_en,
    input  logic [31:0] IDEX_cpsr,
    input  logic [11:0] IDEX_inst_11_0,
    input  logic [3:0]  IDEX_inst_19_16,
    input  logic [3:0]  IDEX_inst_15_12,
    output logic        EXID_rd_we,
    output logic        EXID_cpsr_we,
    output logic [3:0]  EXID_rd_num,
    output logic [31:0] EXID_cpsr,
    output logic        ex_busy,
    output logic [31:0] EXMEM_alu_result,
    output logic [31:0] EXMEM_store_data,
    output logic [31:0] EXMEM_cpsr,
    output logic [3:0]  EXMEM_rd_num,
    output logic [3:0]  EXMEM_mem_write_en,
    output logic        EXMEM_rd_we,
    output logic        EXMEM_cpsr_we,
    output logic        EXMEM_rd_data_sel,
    output logic        EXMEM_ld_byte_or_word,
    output logic        EXMEM_halted
);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d, mul_rm_q, mul_rs_q;
    logic [3:0]  mul_rd_num_q;
    logic        mul_halted_q;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] a);
        return (v >> a) | (v << (6'd32 - {1'b0, a}));
    endfunction

    // Operand2 barrel shifter
    logic [31:0]        op2;
    logic               sh_c;
    logic [4:0]         amt, amt_m1, rot;
    logic [5:0]         lsl_idx;
    logic signed [31:0] rm_s;
    logic               c_in;

    always_comb begin
        c_in    = IDEX_cpsr[29];
        amt     = IDEX_inst_11_0[11:7];
        amt_m1  = amt - 5'd1;
        lsl_idx = 6'd32 - {1'b0, amt};
        rot     = {IDEX_inst_11_0[11:8], 1'b0};
        rm_s    = IDEX_rm_data;
        op2     = IDEX_rm_data;
        sh_c    = c_in;
        if (IDEX_is_imm) begin
            op2  = ror32({24'd0, IDEX_inst_11_0[7:0]}, rot);
            sh_c = (rot != 5'd0) ? op2[31] : c_in;
        end else begin
            unique case (IDEX_inst_11_0[6:5])
                2'b00: if (amt != 5'd0) begin
                    op2  = IDEX_rm_data << amt;
                    sh_c = IDEX_rm_data[lsl_idx[4:0]];
                end
                2'b01: if (amt == 5'd0) begin
                    op2  = 32'd0;
                    sh_c = IDEX_rm_data[31];
                end else begin
                    op2  = IDEX_rm_data >> amt;
                    sh_c = IDEX_rm_data[amt_m1];
                end
                2'b10: if (amt == 5'd0) begin
                    op2  = {32{IDEX_rm_data[31]}};
                    sh_c = IDEX_rm_data[31];
                end else begin
                    op2  = 32'(rm_s >>> amt);
                    sh_c = IDEX_rm_data[amt_m1];
                end
                default: if (amt == 5'd0) begin
                    op2  = {c_in, IDEX_rm_data[31:1]};
                    sh_c = IDEX_rm_data[0];
                end else begin
                    op2  = ror32(IDEX_rm_data, amt);
                    sh_c = IDEX_rm_data[amt_m1];
                end
            endcase
        end
    end

    // ALU, one shared adder; subtracts use a + ~b + 1 so carry = NOT borrow
    logic [31:0] add_a, add_b, alu_res, alu_cpsr;
    logic        add_cin, is_arith, flag_c, flag_v, is_test;
    logic        cpsr_we_eff, rd_we_eff, mul_start;
    logic [32:0] add_sum;
    logic [3:0]  flags, rd_num;

    always_comb begin
        add_a    = IDEX_rn_data;
        add_b    = op2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        alu_res  = 32'd0;
        if (IDEX_is_alu_for_mem_addr) begin
            add_b    = IDEX_up_down ? op2 : ~op2;
            add_cin  = ~IDEX_up_down;
            is_arith = 1'b1;
        end else begin
            unique case (IDEX_alu_sel)
                4'h0, 4'h8: alu_res = IDEX_rn_data & op2;
                4'h1, 4'h9: alu_res = IDEX_rn_data ^ op2;
                4'h2, 4'hA: begin add_b = ~op2; add_cin = 1'b1; is_arith = 1'b1; end
                4'h3: begin add_a = op2; add_b = ~IDEX_rn_data; add_cin = 1'b1; is_arith = 1'b1; end
                4'h4, 4'hB: is_arith = 1'b1;
                4'h5: begin add_cin = c_in; is_arith = 1'b1; end
                4'h6: begin add_b = ~op2; add_cin = c_in; is_arith = 1'b1; end
                4'h7: begin add_a = op2; add_b = ~IDEX_rn_data; add_cin = c_in; is_arith = 1'b1; end
                4'hC: alu_res = IDEX_rn_data | op2;
                4'hD: alu_res = op2;
                4'hE: alu_res = IDEX_rn_data & ~op2;
                default: alu_res = ~op2;
            endcase
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        if (is_arith) alu_res = add_sum[31:0];
        flag_c = is_arith ? add_sum[32] : sh_c;
        flag_v = is_arith ? ((add_a[31] == add_b[31]) && (add_sum[31] != add_a[31])) : IDEX_cpsr[28];
        flags  = {alu_res[31], (alu_res == 32'd0), flag_c, flag_v};

        is_test     = (IDEX_alu_sel[3:2] == 2'b10) && IDEX_alu_or_mac && !IDEX_is_alu_for_mem_addr;
        rd_we_eff   = IDEX_rd_we && !is_test;
        cpsr_we_eff = IDEX_cpsr_we && IDEX_alu_or_mac && !IDEX_is_alu_for_mem_addr;
        alu_cpsr    = IDEX_cpsr;
        if (cpsr_we_eff)
            alu_cpsr[31:28] = (flags & IDEX_cpsr_mask) | (IDEX_cpsr[31:28] & ~IDEX_cpsr_mask);
        rd_num    = IDEX_rd_sel ? IDEX_inst_15_12 : IDEX_inst_19_16;
        mul_start = (state_q == S_IDLE) && !IDEX_alu_or_mac && IDEX_rd_we;
    end

    // Multiplier FSM: one Rs byte per cycle, LSB first
    logic [7:0]  mul_byte;
    logic [31:0] mul_term;

    always_comb begin
        mul_byte = 8'(mul_rs_q >> {cnt_q, 3'b000});
        mul_term = (mul_rm_q * {24'd0, mul_byte}) << {cnt_q, 3'b000};
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        unique case (state_q)
            S_IDLE: if (mul_start) begin
                state_d = S_MUL;
                cnt_d   = 2'd0;
                acc_d   = IDEX_mac_sel ? IDEX_rn_data : 32'd0;
            end
            default: begin
                acc_d = acc_q + mul_term;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (mul_start) begin
            mul_rm_q     <= IDEX_rm_data;
            mul_rs_q     <= IDEX_rs_or_rd_data;
            mul_rd_num_q <= rd_num;
            mul_halted_q <= IDEX_halted;
        end
    end

    // EX/MEM register next state; MUL start and MUL cycles emit bubbles except the final one
    logic [31:0] res_d, cpsr_d;
    logic [3:0]  rd_num_d, mem_we_d;
    logic        rd_we_d, cpsr_we_d, rd_data_sel_d, ld_d, halted_d;

    always_comb begin
        res_d         = 32'd0;
        cpsr_d        = IDEX_cpsr;
        rd_num_d      = rd_num;
        mem_we_d      = 4'd0;
        rd_we_d       = 1'b0;
        cpsr_we_d     = 1'b0;
        rd_data_sel_d = 1'b0;
        ld_d          = 1'b0;
        halted_d      = 1'b0;
        if (state_q == S_MUL) begin
            rd_num_d = mul_rd_num_q;
            if (cnt_q == 2'd3) begin
                res_d         = acc_d;
                rd_we_d       = 1'b1;
                rd_data_sel_d = 1'b1;
                halted_d      = mul_halted_q;
            end
        end else if (!mul_start) begin
            res_d         = alu_res;
            cpsr_d        = alu_cpsr;
            mem_we_d      = IDEX_mem_write_en;
            rd_we_d       = rd_we_eff;
            cpsr_we_d     = cpsr_we_eff;
            rd_data_sel_d = IDEX_rd_data_sel;
            ld_d          = IDEX_ld_byte_or_word;
            halted_d      = IDEX_halted;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            EXMEM_alu_result      <= 32'd0;
            EXMEM_store_data      <= 32'd0;
            EXMEM_cpsr            <= 32'd0;
            EXMEM_rd_num          <= 4'd0;
            EXMEM_mem_write_en    <= 4'd0;
            EXMEM_rd_we           <= 1'b0;
            EXMEM_cpsr_we         <= 1'b0;
            EXMEM_rd_data_sel     <= 1'b0;
            EXMEM_ld_byte_or_word <= 1'b0;
            EXMEM_halted          <= 1'b0;
        end else begin
            EXMEM_alu_result      <= res_d;
            EXMEM_store_data      <= IDEX_rs_or_rd_data;
            EXMEM_cpsr            <= cpsr_d;
            EXMEM_rd_num          <= rd_num_d;
            EXMEM_mem_write_en    <= mem_we_d;
            EXMEM_rd_we           <= rd_we_d;
            EXMEM_cpsr_we         <= cpsr_we_d;
            EXMEM_rd_data_sel     <= rd_data_sel_d;
            EXMEM_ld_byte_or_word <= ld_d;
            EXMEM_halted          <= halted_d;
        end
    end

    always_comb begin
        ex_busy = (state_q == S_MUL);
        if (ex_busy) begin
            EXID_rd_we   = 1'b1;
            EXID_rd_num  = mul_rd_num_q;
            EXID_cpsr_we = 1'b0;
            EXID_cpsr    = IDEX_cpsr;
        end else begin
            EXID_rd_we   = rd_we_eff;
            EXID_rd_num  = rd_num;
            EXID_cpsr_we = cpsr_we_eff;
            EXID_cpsr    = alu_cpsr;
        end
    end

endmodule

// File: tb/tb_arm_ex_stage.sv
// Directed bench for arm_ex_stage: shifter/ALU/flag vectors, address generation, MLA timing,
// and reset in the middle of a multiply.
module tb_arm_ex_stage;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] rn, rm, rs, cpsr;
    logic        rd_we, cpsr_we, is_imm, alu_or_mac, up_down, mac_sel, rd_sel;
    logic        rd_data_sel, mem_addr, ld_bw, halted;
    logic [3:0]  alu_sel, mask, mem_we, i19_16, i15_12;
    logic [11:0] i11_0;

    logic        exid_rd_we, exid_cpsr_we, ex_busy;
    logic [3:0]  exid_rd_num, o_rd_num, o_mem_we;
    logic [31:0] exid_cpsr, o_res, o_store, o_cpsr;
    logic        o_rd_we, o_cpsr_we, o_rd_data_sel, o_ld, o_halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arm_ex_stage dut (
        .clk(clk), .rst_b(rst_b),
        .IDEX_rn_data(rn), .IDEX_rm_data(rm), .IDEX_rs_or_rd_data(rs),
        .IDEX_rd_we(rd_we), .IDEX_cpsr_we(cpsr_we), .IDEX_is_imm(is_imm),
        .IDEX_alu_or_mac(alu_or_mac), .IDEX_up_down(up_down), .IDEX_mac_sel(mac_sel),
        .IDEX_rd_sel(rd_sel), .IDEX_rd_data_sel(rd_data_sel),
        .IDEX_is_alu_for_mem_addr(mem_addr), .IDEX_ld_byte_or_word(ld_bw),
        .IDEX_halted(halted), .IDEX_alu_sel(alu_sel), .IDEX_cpsr_mask(mask),
        .IDEX_mem_write_en(mem_we), .IDEX_cpsr(cpsr), .IDEX_inst_11_0(i11_0),
        .IDEX_inst_19_16(i19_16), .IDEX_inst_15_12(i15_12),
        .EXID_rd_we(exid_rd_we), .EXID_cpsr_we(exid_cpsr_we), .EXID_rd_num(exid_rd_num),
        .EXID_cpsr(exid_cpsr), .ex_busy(ex_busy),
        .EXMEM_alu_result(o_res), .EXMEM_store_data(o_store), .EXMEM_cpsr(o_cpsr),
        .EXMEM_rd_num(o_rd_num), .EXMEM_mem_write_en(o_mem_we), .EXMEM_rd_we(o_rd_we),
        .EXMEM_cpsr_we(o_cpsr_we), .EXMEM_rd_data_sel(o_rd_data_sel),
        .EXMEM_ld_byte_or_word(o_ld), .EXMEM_halted(o_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        rn = 0; rm = 0; rs = 0; cpsr = 0;
        rd_we = 0; cpsr_we = 0; is_imm = 0; alu_or_mac = 1; up_down = 0; mac_sel = 0;
        rd_sel = 0; rd_data_sel = 0; mem_addr = 0; ld_bw = 0; halted = 0;
        alu_sel = 0; mask = 0; mem_we = 0; i19_16 = 0; i15_12 = 0; i11_0 = 0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [11:0] inst, input logic imm, input logic [31:0] c,
                       input logic [3:0] m);
        bubble();
        alu_sel = op; rn = a; rm = b; i11_0 = inst; is_imm = imm; cpsr = c; mask = m;
        rd_we = 1; cpsr_we = 1; rd_sel = 1; i15_12 = 4'd3; i19_16 = 4'd9;
    endtask

    initial begin
        bubble();
        rst_b = 0;
        #3;
        check("rst_busy", 32'(ex_busy), 32'd0);
        check("rst_rd_we", 32'(o_rd_we), 32'd0);
        check("rst_result", o_res, 32'd0);
        check("rst_cpsr", o_cpsr, 32'd0);
        @(negedge clk);
        rst_b = 1;
        tick();

        // ADD overflow into sign bit, with halted propagating
        alu(4'h4, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 32'd0, 4'hF);
        halted = 1;
        tick();
        check("add_res", o_res, 32'h8000_0000);
        check("add_cpsr", o_cpsr, 32'h9000_0000);
        check("add_rd_num", 32'(o_rd_num), 32'd3);
        check("add_halted", 32'(o_halted), 32'd1);

        // MOV Rm LSR #0 means shift by 32
        alu(4'hD, 32'd0, 32'h8000_0001, 12'h020, 1'b0, 32'd0, 4'hF);
        tick();
        check("lsr32_res", o_res, 32'd0);
        check("lsr32_cpsr", o_cpsr, 32'h6000_0000);

        // rotated immediate, only C written
        alu(4'hD, 32'd0, 32'd0, 12'h4FF, 1'b1, 32'd0, 4'h2);
        tick();
        check("rotimm_res", o_res, 32'hFF00_0000);
        check("rotimm_cpsr", o_cpsr, 32'h2000_0000);

        // SBC with C clear: 10 - 3 - 1
        alu(4'h6, 32'd10, 32'd0, 12'h003, 1'b1, 32'd0, 4'hF);
        tick();
        check("sbc_res", o_res, 32'd6);
        check("sbc_cpsr", o_cpsr, 32'h2000_0000);

        // ASR #4
        alu(4'hD, 32'd0, 32'h8000_0010, 12'h240, 1'b0, 32'h2000_0000, 4'hF);
        tick();
        check("asr_res", o_res, 32'hF800_0001);
        check("asr_cpsr", o_cpsr, 32'h8000_0000);

        // ROR #0 is RRX through C
        alu(4'hD, 32'd0, 32'h0000_0003, 12'h060, 1'b0, 32'h2000_0000, 4'hF);
        tick();
        check("rrx_res", o_res, 32'h8000_0001);
        check("rrx_cpsr", o_cpsr, 32'hA000_0000);

        // load/store address, down
        alu(4'h4, 32'h100, 32'd0, 12'h00C, 1'b1, 32'hA000_0000, 4'hF);
        mem_addr = 1; up_down = 0; rs = 32'hDEAD_BEEF; mem_we = 4'hF;
        tick();
        check("addr_res", o_res, 32'h0000_00F4);
        check("addr_store", o_store, 32'hDEAD_BEEF);
        check("addr_cpsr_we", 32'(o_cpsr_we), 32'd0);
        check("addr_cpsr", o_cpsr, 32'hA000_0000);
        check("addr_mem_we", 32'(o_mem_we), 32'hF);

        // CMP equal: forwarding view shows new flags before the edge
        alu(4'hA, 32'd3, 32'd0, 12'h003, 1'b1, 32'd0, 4'hF);
        #1;
        check("cmp_exid_cpsr", exid_cpsr, 32'h6000_0000);
        check("cmp_exid_rd_we", 32'(exid_rd_we), 32'd0);
        check("cmp_exid_cpsr_we", 32'(exid_cpsr_we), 32'd1);
        tick();
        check("cmp_rd_we", 32'(o_rd_we), 32'd0);
        check("cmp_cpsr", o_cpsr, 32'h6000_0000);

        bubble();
        tick();
        check("bub_rd_we", 32'(o_rd_we), 32'd0);
        check("bub_cpsr_we", 32'(o_cpsr_we), 32'd0);
        check("bub_halted", 32'(o_halted), 32'd0);

        // MLA: 0x12345678 * 0x9ABCDEF0 + 5
        bubble();
        alu_or_mac = 0; rd_we = 1; mac_sel = 1; rn = 32'd5; rm = 32'h1234_5678;
        rs = 32'h9ABC_DEF0; rd_sel = 0; i19_16 = 4'd7;
        tick();
        check("mla_busy0", 32'(ex_busy), 32'd1);
        check("mla_bub0", 32'(o_rd_we), 32'd0);
        alu(4'h4, 32'h1, 32'd0, 12'h001, 1'b1, 32'd0, 4'hF);
        for (int i = 1; i < 4; i++) begin
            #1;
            check("mla_exid_rd_we", 32'(exid_rd_we), 32'd1);
            check("mla_exid_rd_num", 32'(exid_rd_num), 32'd7);
            tick();
            check("mla_busy", 32'(ex_busy), 32'd1);
            check("mla_bub_rd_we", 32'(o_rd_we), 32'd0);
            check("mla_bub_cpsr_we", 32'(o_cpsr_we), 32'd0);
        end
        bubble();
        tick();
        check("mla_busy_end", 32'(ex_busy), 32'd0);
        check("mla_res", o_res, 32'h242D_2085);
        check("mla_rd_we", 32'(o_rd_we), 32'd1);
        check("mla_rd_num", 32'(o_rd_num), 32'd7);
        check("mla_rd_data_sel", 32'(o_rd_data_sel), 32'd1);
        check("mla_cpsr_we", 32'(o_cpsr_we), 32'd0);
        tick();
        check("mla_after", 32'(o_rd_we), 32'd0);

        // MUL ignores Rn: 0xFFFFFFFF squared mod 2^32
        bubble();
        alu_or_mac = 0; rd_we = 1; rn = 32'd99; rm = 32'hFFFF_FFFF; rs = 32'hFFFF_FFFF;
        rd_sel = 1; i15_12 = 4'd2;
        tick();
        bubble();
        repeat (4) tick();
        check("mul_res", o_res, 32'd1);
        check("mul_rd_we", 32'(o_rd_we), 32'd1);

        // reset in the 2nd MUL cycle
        bubble();
        alu_or_mac = 0; rd_we = 1; rm = 32'd3; rs = 32'd4; i19_16 = 4'd5;
        tick();
        bubble();
        tick();
        check("rstmul_busy_pre", 32'(ex_busy), 32'd1);
        rst_b = 0;
        #1;
        check("rstmul_busy", 32'(ex_busy), 32'd0);
        check("rstmul_rd_we", 32'(o_rd_we), 32'd0);
        check("rstmul_res", o_res, 32'd0);
        check("rstmul_exid", 32'(exid_rd_we), 32'd0);
        @(negedge clk);
        rst_b = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstmul_no_write", 32'(o_rd_we), 32'd0);
            check("rstmul_idle", 32'(ex_busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
